adc_capture: RTL and testbench

Sample-side counterpart of the ADC clock divider. It detects rising edges of the divided ADC clock, registers the 12-bit parallel ADC word on each edge, and waits for an armed trigger (level crossing with selectable slope, or forced). It then streams a fixed-length record of samples to a sample-memory write port. It sits between the ADC pins and the waveform buffer, and signals record completion to the display/readout logic.

---
 rtl/adc_capture.sv | 143 ++++++++++++++
 tb/tb_adc_capture.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// ADC sample capture: edge-detects the divided ADC clock, triggers on a level crossing or a force,
// then writes one DEPTH-sample record. Define ADC_CAPTURE_AVG_EN to average sample pairs.
module adc_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_adc,
    input  logic [11:0]   adc_data,
    input  logic          arm,
    input  logic          force_trig,
    input  logic [11:0]   trig_level,
    input  logic          trig_slope,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [11:0]   wr_data,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]    state;
    logic          clk_adc_q;
    logic [11:0]   cur;
    logic [11:0]   prev;
    logic          sample_vld;
    logic          have_prev;
    logic [AW-1:0] addr_cnt;

    logic          strb;
    logic          rise_hit;
    logic          fall_hit;
    logic          trig;
    logic          arm_ok;

`ifdef ADC_CAPTURE_AVG_EN
    logic          phase;
    logic [11:0]   pair_first;
    logic [12:0]   pair_sum;
`endif

    always_comb begin
        strb     = clk_adc & ~clk_adc_q;
        rise_hit = (prev < trig_level) && (cur >= trig_level);
        fall_hit = (prev > trig_level) && (cur <= trig_level);
        trig     = force_trig | (have_prev & (trig_slope ? fall_hit : rise_hit));
        arm_ok   = arm && ((state == StIdle) || (state == StDone));
`ifdef ADC_CAPTURE_AVG_EN
        pair_sum = {1'b0, pair_first} + {1'b0, adc_data};
`endif
    end

    assign busy = (state == StArmed) || (state == StCapture);
    assign done = (state == StDone);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            clk_adc_q  <= 1'b0;
            cur        <= 12'd0;
            prev       <= 12'd0;
            sample_vld <= 1'b0;
            have_prev  <= 1'b0;
            addr_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 12'd0;
`ifdef ADC_CAPTURE_AVG_EN
            phase      <= 1'b0;
            pair_first <= 12'd0;
`endif
        end else begin
            clk_adc_q  <= clk_adc;
            sample_vld <= 1'b0;
            wr_en      <= 1'b0;

`ifdef ADC_CAPTURE_AVG_EN
            if (strb) begin
                if (!phase) begin
                    pair_first <= adc_data;
                    phase      <= 1'b1;
                end else begin
                    cur        <= pair_sum[12:1];
                    prev       <= cur;
                    sample_vld <= 1'b1;
                    phase      <= 1'b0;
                end
            end
            // Arming restarts pairing so the next strobe opens a new pair.
            if (arm_ok) begin
                phase <= 1'b0;
            end
`else
            if (strb) begin
                cur        <= adc_data;
                prev       <= cur;
                sample_vld <= 1'b1;
            end
`endif

            case (state)
                StIdle, StDone: begin
                    // A sample landing with arm only seeds prev for the next evaluation.
                    if (arm_ok) begin
                        state     <= StArmed;
                        have_prev <= sample_vld;
                    end
                end
                StArmed: begin
                    if (sample_vld) begin
                        if (trig) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= '0;
                            wr_data  <= cur;
                            addr_cnt <= AW'(1);
                            state    <= StCapture;
                        end else begin
                            have_prev <= 1'b1;
                        end
                    end
                end
                StCapture: begin
                    if (sample_vld) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= cur;
                        addr_cnt <= addr_cnt + AW'(1);
                        if (addr_cnt == AW'(DEPTH - 1)) begin
                            state <= StDone;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: trigger table, hand-written timing/reset sequences and
// randomized streams scored against a sample-level reference model.
module tb_adc_capture;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_adc = 1'b0;
    logic [11:0]   adc_data = 12'd0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic [11:0]   trig_level = 12'd0;
    logic          trig_slope = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          done;

    adc_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_adc    (clk_adc),
        .adc_data   (adc_data),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one call per ADC sample, state kept as plain integers.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  m_state;      // 0 idle, 1 armed, 2 capture, 3 done
    int  m_cnt;
    int  m_last;
    bit  m_have_prev;

    function automatic void model_reset();
        m_state     = 0;
        m_cnt       = 0;
        m_last      = 0;
        m_have_prev = 0;
        exp_q.delete();
    endfunction

    function automatic void model_arm();
        if (m_state == 0 || m_state == 3) begin
            m_state     = 1;
            m_have_prev = 0;
        end
    endfunction

    function automatic bit crosses(input int p, input int c, input int lvl, input bit slope);
        if (slope) return (p > lvl) && (c <= lvl);
        return (p < lvl) && (c >= lvl);
    endfunction

    function automatic void model_sample(input int d, input bit frc);
        int p;
        wr_t w;
        p      = m_last;
        m_last = d;
        if (m_state == 1) begin
            if (frc || (m_have_prev && crosses(p, d, int'(trig_level), trig_slope))) begin
                w.addr = 0;
                w.data = d;
                exp_q.push_back(w);
                m_cnt   = 1;
                m_state = 2;
            end else begin
                m_have_prev = 1;
            end
        end else if (m_state == 2) begin
            w.addr = m_cnt;
            w.data = d;
            exp_q.push_back(w);
            m_cnt++;
            if (m_cnt == DEPTH) m_state = 3;
        end
    endfunction

    // Write monitor / scoreboard.
    int n_writes   = 0;
    int first_data = -1;
    int last_data  = -1;
    int last_addr  = -1;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_t e;
            n_writes++;
            last_data = int'(wr_data);
            last_addr = int'(wr_addr);
            if (wr_addr == 0) first_data = int'(wr_data);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                check("done_at_write", int'(done), int'(e.addr == DEPTH - 1));
                check("busy_at_write", int'(busy), int'(e.addr != DEPTH - 1));
            end
        end
    end

    task automatic do_sample(input int d, input bit frc);
        @(negedge clk);
        adc_data   = 12'(d);
        force_trig = frc;
        clk_adc    = 1'b1;
        model_sample(d, frc);
        repeat (2) @(negedge clk);
        clk_adc = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        model_arm();
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        force_trig = 1'b0;
        clk_adc    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_status(input string name);
        check({name, "_busy"}, int'(busy), int'(m_state == 1 || m_state == 2));
        check({name, "_done"}, int'(done), int'(m_state == 3));
    endtask

    typedef struct {
        logic        slope;
        logic [11:0] level;
        logic        frc;
        logic [11:0] s [4];
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs [8];

    task automatic set_vec(input int i, input logic slope, input logic [11:0] level,
                           input logic frc, input logic [11:0] s0, input logic [11:0] s1,
                           input logic [11:0] s2, input logic [11:0] s3, input logic [1:0] idx);
        vecs[i].slope = slope;
        vecs[i].level = level;
        vecs[i].frc   = frc;
        vecs[i].s[0]  = s0;
        vecs[i].s[1]  = s1;
        vecs[i].s[2]  = s2;
        vecs[i].s[3]  = s3;
        vecs[i].idx   = idx;
    endtask

    initial begin
        int n_before;

        set_vec(0, 1'b0, 12'h800, 1'b0, 12'h7F0, 12'h7F8, 12'h800, 12'h808, 2'd2);
        set_vec(1, 1'b1, 12'h800, 1'b0, 12'h900, 12'h810, 12'h7F0, 12'h7E0, 2'd2);
        set_vec(2, 1'b1, 12'h800, 1'b0, 12'h700, 12'h900, 12'h7F0, 12'h7F0, 2'd2);
        set_vec(3, 1'b0, 12'h800, 1'b1, 12'h123, 12'h123, 12'h123, 12'h123, 2'd0);
        set_vec(4, 1'b0, 12'h800, 1'b0, 12'h900, 12'h900, 12'h700, 12'h900, 2'd3);
        set_vec(5, 1'b0, 12'h100, 1'b0, 12'h0FF, 12'h100, 12'h100, 12'h100, 2'd1);
        set_vec(6, 1'b1, 12'h200, 1'b0, 12'h300, 12'h200, 12'h200, 12'h200, 2'd1);
        set_vec(7, 1'b1, 12'h200, 1'b0, 12'h200, 12'h1F0, 12'h250, 12'h100, 2'd3);

        // Reset hold with the ADC clock running.
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_hold", int'({wr_en, busy, done, wr_addr, wr_data}), 0);
            clk_adc = ~clk_adc;
        end
        rst_n   = 1'b1;
        clk_adc = 1'b0;
        for (int i = 0; i < 6; i++) do_sample(int'($urandom_range(0, 4095)), 1'b0);
        check("no_write_unarmed", n_writes, 0);
        chk_status("idle");

        // Trigger table.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            trig_level = vecs[v].level;
            trig_slope = vecs[v].slope;
            first_data = -1;
            do_arm();
            for (int i = 0; i < 4; i++) do_sample(int'(vecs[v].s[i]), vecs[v].frc);
            for (int i = 0; i < 8; i++) do_sample(int'(vecs[v].s[3]), 1'b0);
            check($sformatf("vec%0d_first", v), first_data, int'(vecs[v].s[vecs[v].idx]));
            check($sformatf("vec%0d_done", v), int'(done), 1);
            check($sformatf("vec%0d_drained", v), exp_q.size(), 0);
        end

        // Ramp through a rising crossing: 0x800 at addr 0, +8 per address.
        do_reset();
        trig_level = 12'h800;
        trig_slope = 1'b0;
        do_arm();
        for (int i = 0; i < 12; i++) do_sample(12'h7F0 + 8 * i, 1'b0);
        check("ramp_last_addr", last_addr, 7);
        check("ramp_last_data", last_data, 12'h838);
        check("ramp_done", int'(done), 1);
        check("ramp_busy", int'(busy), 0);
        check("ramp_drained", exp_q.size(), 0);

        // Write latency and single-cycle strobe on a forced trigger.
        do_reset();
        do_arm();
        @(negedge clk);
        adc_data   = 12'h3C5;
        force_trig = 1'b1;
        clk_adc    = 1'b1;
        model_sample(12'h3C5, 1'b1);
        @(negedge clk);
        check("lat_e0", int'(wr_en), 0);
        @(negedge clk);
        check("lat_e1", int'(wr_en), 1);
        check("lat_addr", int'(wr_addr), 0);
        check("lat_data", int'(wr_data), 12'h3C5);
        clk_adc = 1'b0;
        @(negedge clk);
        check("lat_pulse", int'(wr_en), 0);
        for (int i = 0; i < 7; i++) do_sample(12'h3C6 + i, 1'b0);
        check("lat_done", int'(done), 1);
        check("lat_drained", exp_q.size(), 0);

        // Arm during capture is ignored; reset mid-record aborts it.
        do_reset();
        do_arm();
        do_sample(12'h111, 1'b1);
        do_sample(12'h222, 1'b0);
        do_arm();
        do_sample(12'h333, 1'b0);
        do_sample(12'h444, 1'b0);
        check("abort_last_addr", last_addr, 3);
        check("abort_busy_before", int'(busy), 1);
        @(negedge clk);
        adc_data = 12'h555;
        clk_adc  = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        check("abort_no_write", int'(wr_en), 0);
        clk_adc = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        n_before = n_writes;
        for (int i = 0; i < 4; i++) do_sample(12'h600 + i, 1'b1);
        check("abort_needs_rearm", n_writes - n_before, 0);
        chk_status("abort_idle");
        first_data = -1;
        do_arm();
        do_sample(12'h666, 1'b1);
        check("abort_rearm_first", first_data, 12'h666);

        // Randomized streams with stray arms and forces.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            trig_level = 12'($urandom_range(12'h400, 12'hC00));
            trig_slope = 1'($urandom_range(0, 1));
            do_arm();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 9) == 0) do_arm();
                do_sample(int'($urandom_range(0, 4095)), ($urandom_range(0, 19) == 0));
                chk_status($sformatf("rand%0d", r));
            end
            repeat (4) @(negedge clk);
            check($sformatf("rand%0d_drained", r), exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
